// File: rtl/wbs_mem_bridge.sv
// Wishbone slave front-end: decodes the 0x3000_0000-0x3004_FFFF map, pairs 32-bit writes into
// leaf/query entries, drives node/leaf/query write ports, serves best reads, hosts control regs.
// Optional build macro WBS_DONE_IRQ_EN adds a done-rising-edge interrupt on irq_o.
module wbs_mem_bridge #(
   parameter int DATA_WIDTH = 11,
   parameter int NODE_AW    = 6,
   parameter int LEAF_AW    = 9,
   parameter int QUERY_AW   = 9,
   parameter int BEST_AW    = 9
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic                    node_wen,
   output logic [NODE_AW-1:0]      node_waddr,
   output logic [2*DATA_WIDTH-1:0] node_wdata,
   output logic                    leaf_wen,
   output logic [LEAF_AW-1:0]      leaf_waddr,
   output logic [63:0]             leaf_wdata,
   output logic                    query_wen,
   output logic [QUERY_AW-1:0]     query_waddr,
   output logic [5*DATA_WIDTH-1:0] query_wdata,
   output logic                    best_ren,
   output logic [BEST_AW-1:0]      best_raddr,
   input  logic [DATA_WIDTH-1:0]   best_rdata,
   output logic                    fsm_start,
   input  logic                    fsm_done,
   input  logic                    fsm_busy,
   output logic                    mode_o,
   output logic                    debug_o,
   output logic                    irq_o
);

   localparam logic [15:0] BANK_CTRL  = 16'h3000;
   localparam logic [15:0] BANK_QUERY = 16'h3001;
   localparam logic [15:0] BANK_LEAF  = 16'h3002;
   localparam logic [15:0] BANK_BEST  = 16'h3003;
   localparam logic [15:0] BANK_NODE  = 16'h3004;

   localparam logic [4:0] OFF_MODE  = 5'h00;
   localparam logic [4:0] OFF_DEBUG = 5'h04;
   localparam logic [4:0] OFF_DONE  = 5'h08;
   localparam logic [4:0] OFF_START = 5'h0C;
   localparam logic [4:0] OFF_BUSY  = 5'h10;

   localparam int HIDX_W = (LEAF_AW > QUERY_AW) ? LEAF_AW : QUERY_AW;

   typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

   state_t              state;
   logic                mode_q;
   logic                debug_q;
   logic                err_q;
   logic                hold_vld;
   logic [31:0]         hold;
   logic [HIDX_W-1:0]   hold_idx;

   logic                req;
   logic                wr;
   logic                upper;
   logic [15:0]         bank;
   logic [4:0]          off;
   logic                is_ctrl, is_query, is_leaf, is_best, is_node;
   logic [HIDX_W-1:0]   leaf_idx, query_idx;
   logic                leaf_up, query_up, leaf_hit, query_hit;
   logic [63:0]         pair;
   logic [31:0]         rd_val;

   // Decode is only live in IDLE so every side effect fires exactly once per transfer.
   assign req       = !wb_rst_i && (state == IDLE) && wbs_cyc_i && wbs_stb_i;
   assign wr        = wbs_we_i && (wbs_sel_i == 4'hF);
   assign upper     = wbs_adr_i[2];
   assign bank      = wbs_adr_i[31:16];
   assign off       = wbs_adr_i[4:0];
   assign is_ctrl   = (bank == BANK_CTRL);
   assign is_query  = (bank == BANK_QUERY);
   assign is_leaf   = (bank == BANK_LEAF);
   assign is_best   = (bank == BANK_BEST);
   assign is_node   = (bank == BANK_NODE);

   assign leaf_idx  = HIDX_W'(wbs_adr_i[3 +: LEAF_AW]);
   assign query_idx = HIDX_W'(wbs_adr_i[3 +: QUERY_AW]);
   assign leaf_up   = req && is_leaf && wr && upper;
   assign query_up  = req && is_query && wr && upper;
   assign leaf_hit  = leaf_up && hold_vld && (hold_idx == leaf_idx);
   assign query_hit = query_up && hold_vld && (hold_idx == query_idx);
   assign pair      = {wbs_dat_i, hold};

   assign leaf_wen    = leaf_hit;
   assign leaf_waddr  = leaf_hit ? wbs_adr_i[3 +: LEAF_AW] : '0;
   assign leaf_wdata  = leaf_hit ? pair : '0;
   assign query_wen   = query_hit;
   assign query_waddr = query_hit ? wbs_adr_i[3 +: QUERY_AW] : '0;
   assign query_wdata = query_hit ? pair[5*DATA_WIDTH-1:0] : '0;

   assign node_wen    = req && is_node && wr;
   assign node_waddr  = node_wen ? wbs_adr_i[2 +: NODE_AW] : '0;
   assign node_wdata  = node_wen ? wbs_dat_i[2*DATA_WIDTH-1:0] : '0;

   // best_ren rides the decode cycle so best_rdata is ready when RD_WAIT captures it.
   assign best_ren    = req && is_best && !wbs_we_i;
   assign best_raddr  = best_ren ? wbs_adr_i[3 +: BEST_AW] : '0;

   assign fsm_start   = req && is_ctrl && wr && (off == OFF_START);

   assign mode_o      = mode_q;
   assign debug_o     = debug_q;

   always_comb begin
      rd_val = '0;
      if (req && !wbs_we_i && is_ctrl) begin
         case (off)
            OFF_MODE:  rd_val[0]   = mode_q;
            OFF_DEBUG: rd_val[1:0] = {err_q, debug_q};
            OFF_DONE:  rd_val[0]   = fsm_done;
            OFF_BUSY:  rd_val[0]   = fsm_busy;
            default:   rd_val      = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         mode_q    <= 1'b0;
         debug_q   <= 1'b0;
         err_q     <= 1'b0;
         hold_vld  <= 1'b0;
         hold      <= '0;
         hold_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (best_ren) begin
                     state <= RD_WAIT;
                  end else begin
                     state     <= ACK;
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= rd_val;
                  end
                  if (is_ctrl && wr && (off == OFF_MODE))
                     mode_q <= wbs_dat_i[0];
                  if (is_ctrl && wr && (off == OFF_DEBUG)) begin
                     debug_q <= wbs_dat_i[0];
                     err_q   <= 1'b0;
                  end
                  if ((is_leaf || is_query) && wr && !upper) begin
                     hold     <= wbs_dat_i;
                     hold_idx <= is_leaf ? leaf_idx : query_idx;
                     hold_vld <= 1'b1;
                  end
                  if (leaf_hit || query_hit)
                     hold_vld <= 1'b0;
                  // Orphaned or mismatched upper halves are dropped and flagged.
                  if ((leaf_up && !leaf_hit) || (query_up && !query_hit))
                     err_q <= 1'b1;
               end
            end
            RD_WAIT: begin
               state     <= ACK;
               wbs_ack_o <= 1'b1;
               wbs_dat_o <= {{(32-DATA_WIDTH){1'b0}}, best_rdata};
            end
            ACK: begin
               state     <= IDLE;
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
            end
            default: begin
               state     <= IDLE;
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
            end
         endcase
      end
   end

`ifdef WBS_DONE_IRQ_EN
   logic done_q;
   logic irq_q;
   logic done_rd;

   assign done_rd = req && !wbs_we_i && is_ctrl && (off == OFF_DONE);
   assign irq_o   = irq_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         done_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         done_q <= fsm_done;
         if (fsm_done && !done_q)
            irq_q <= 1'b1;
         else if (done_rd)
            irq_q <= 1'b0;
      end
   end
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wbs_mem_bridge.sv
// Randomized bench for wbs_mem_bridge against a transaction-level model of the register map
// and the lower/upper write pairing.
module tb_wbs_mem_bridge;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        node_wen, leaf_wen, query_wen, best_ren, fsm_start;
   logic [5:0]  node_waddr;
   logic [21:0] node_wdata;
   logic [8:0]  leaf_waddr, query_waddr, best_raddr;
   logic [63:0] leaf_wdata;
   logic [54:0] query_wdata;
   logic [10:0] best_rdata = '0;
   logic        fsm_done = 1'b0, fsm_busy = 1'b0;
   logic        mode_o, debug_o, irq_o;

`ifdef WBS_DONE_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   wbs_mem_bridge dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .node_wen(node_wen), .node_waddr(node_waddr), .node_wdata(node_wdata),
      .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wdata(leaf_wdata),
      .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
      .best_ren(best_ren), .best_raddr(best_raddr), .best_rdata(best_rdata),
      .fsm_start(fsm_start), .fsm_done(fsm_done), .fsm_busy(fsm_busy),
      .mode_o(mode_o), .debug_o(debug_o), .irq_o(irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // best-array memory: data valid the cycle after best_ren
   logic [10:0] best_mem [512];
   always @(posedge wb_clk_i) if (best_ren) best_rdata <= best_mem[best_raddr];

   int vecs = 0, errs = 0;

   // reference model state
   logic        m_mode, m_debug, m_err, m_hvld;
   logic [31:0] m_hold;
   int          m_hidx;

   // side-effect monitor
   bit          mon_en = 0;
   int          n_node, n_leaf, n_query, n_ren, n_start, n_ack;
   logic [5:0]  c_node_addr;
   logic [21:0] c_node_data;
   logic [8:0]  c_leaf_addr, c_query_addr, c_best_addr;
   logic [63:0] c_leaf_data;
   logic [54:0] c_query_data;
   logic        ack_after;
   logic [31:0] dat_after;

   always @(negedge wb_clk_i) begin
      if (mon_en) begin
         if (node_wen)  begin n_node++;  c_node_addr = node_waddr;   c_node_data = node_wdata;   end
         if (leaf_wen)  begin n_leaf++;  c_leaf_addr = leaf_waddr;   c_leaf_data = leaf_wdata;   end
         if (query_wen) begin n_query++; c_query_addr = query_waddr; c_query_data = query_wdata; end
         if (best_ren)  begin n_ren++;   c_best_addr = best_raddr; end
         if (fsm_start) n_start++;
         if (wbs_ack_o) n_ack++;
      end
   end

   task automatic mon_clear();
      n_node = 0; n_leaf = 0; n_query = 0; n_ren = 0; n_start = 0; n_ack = 0;
      c_node_addr = '0; c_node_data = '0; c_leaf_addr = '0; c_leaf_data = '0;
      c_query_addr = '0; c_query_data = '0; c_best_addr = '0;
   endtask

   task automatic wb_xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
      @(posedge wb_clk_i); #1;
      mon_clear();
      mon_en = 1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = w; wbs_sel_i = s; wbs_adr_i = a; wbs_dat_i = d;
      lat = -1; rd = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin lat = i; rd = wbs_dat_o; break; end
      end
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      @(negedge wb_clk_i);
      ack_after = wbs_ack_o; dat_after = wbs_dat_o;
      #1 mon_en = 0;
   endtask

   task automatic do_reset();
      @(posedge wb_clk_i); #1 wb_rst_i = 1;
      @(posedge wb_clk_i); #1 wb_rst_i = 0;
      m_mode = 0; m_debug = 0; m_err = 0; m_hvld = 0; m_hold = '0; m_hidx = 0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; int lat;
      wb_rst_i = 1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3004_0004; wbs_dat_i = 32'h0000_B807;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      vecs++;
      if ({wbs_ack_o, node_wen, leaf_wen, query_wen, best_ren, fsm_start, mode_o, debug_o, irq_o} !== 9'b0) begin
         errs++; $display("FAIL reset_strobes got %b want 0", {wbs_ack_o, node_wen, leaf_wen, query_wen, best_ren, fsm_start, mode_o, debug_o, irq_o});
      end
      vecs++;
      if ({wbs_dat_o, node_waddr, node_wdata, leaf_waddr, leaf_wdata, query_waddr, query_wdata, best_raddr} !== '0) begin
         errs++; $display("FAIL reset_data_addr got nonzero dat_o=%h want 0", wbs_dat_o);
      end
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wb_rst_i = 0;
      m_mode = 0; m_debug = 0; m_err = 0; m_hvld = 0; m_hold = '0; m_hidx = 0;

      // reset while a best read sits in RD_WAIT: no ack may follow
      @(posedge wb_clk_i); #1;
      mon_clear(); mon_en = 1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3003_0008;
      @(posedge wb_clk_i); #1 wb_rst_i = 1; wbs_cyc_i = 0; wbs_stb_i = 0;
      @(posedge wb_clk_i); #1 wb_rst_i = 0;
      repeat (2) @(negedge wb_clk_i);
      #1 mon_en = 0;
      vecs++;
      if (n_ack !== 0) begin errs++; $display("FAIL reset_abort_ack got %0d acks want 0", n_ack); end

      // reset drops a held lower half
      wb_xfer(1, 4'hF, 32'h3002_0010, 32'h1111_2222, rd, lat);
      do_reset();
      wb_xfer(1, 4'hF, 32'h3002_0014, 32'h3333_4444, rd, lat);
      m_err = 1;
      vecs++;
      if (n_leaf !== 0) begin errs++; $display("FAIL reset_hold_wen got %0d want 0", n_leaf); end
      wb_xfer(0, 4'hF, 32'h3000_0004, 32'h0, rd, lat);
      vecs++;
      if (rd !== {30'b0, m_err, m_debug}) begin errs++; $display("FAIL reset_hold_err got %h want %h", rd, {30'b0, m_err, m_debug}); end
   endtask

   task automatic test_ctrl();
      logic [31:0] rd, mv, dv; int lat;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         mv = $urandom; dv = $urandom;
         wb_xfer(1, 4'hF, 32'h3000_0000, mv, rd, lat); m_mode = mv[0];
         wb_xfer(1, 4'hF, 32'h3000_0004, dv, rd, lat); m_debug = dv[0]; m_err = 0;
         vecs++;
         if (lat !== 1) begin errs++; $display("FAIL ctrl_wr_latency got %0d want 1", lat); end
         wb_xfer(1, 4'h3, 32'h3000_0000, ~mv, rd, lat);
         vecs++;
         if ({mode_o, debug_o} !== {m_mode, m_debug}) begin errs++; $display("FAIL ctrl_outputs got %b want %b", {mode_o, debug_o}, {m_mode, m_debug}); end
         wb_xfer(0, 4'hF, 32'h3000_0000, 32'h0, rd, lat);
         vecs++;
         if (rd !== {31'b0, m_mode}) begin errs++; $display("FAIL ctrl_mode_rd got %h want %h", rd, {31'b0, m_mode}); end
         vecs++;
         if (lat !== 1 || n_ack !== 1 || ack_after !== 0 || dat_after !== 0) begin
            errs++; $display("FAIL ctrl_ack_shape got lat=%0d acks=%0d after=%b/%h want 1/1/0/0", lat, n_ack, ack_after, dat_after);
         end
         wb_xfer(0, 4'hF, 32'h3000_0004, 32'h0, rd, lat);
         vecs++;
         if (rd !== {30'b0, m_err, m_debug}) begin errs++; $display("FAIL ctrl_debug_rd got %h want %h", rd, {30'b0, m_err, m_debug}); end
      end
   endtask

   task automatic test_pairs(input bit is_leaf);
      logic [31:0] base, adr, dat, rd; logic [3:0] sel; logic [63:0] exp_d, got_d, mask;
      int lat, idx, kind, exp_n, got_n, got_a; bit up;
      base = is_leaf ? 32'h3002_0000 : 32'h3001_0000;
      mask = is_leaf ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h007F_FFFF_FFFF_FFFF;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         kind = $urandom_range(0, 5);
         up = (kind == 3 || kind == 4) ? 1'b1 : (kind == 5 ? 1'($urandom_range(0, 1)) : 1'b0);
         idx = $urandom_range(0, 3); if (idx == 3) idx = 511;
         if (up && m_hvld && $urandom_range(0, 3) != 0) idx = m_hidx;
         sel = (kind == 5) ? 4'($urandom_range(0, 14)) : 4'hF;
         dat = $urandom;
         adr = base | (32'(idx) << 3) | (up ? 32'd4 : 32'd0);
         wb_xfer(1, sel, adr, dat, rd, lat);
         exp_n = 0; exp_d = '0;
         if (sel == 4'hF) begin
            if (!up) begin m_hold = dat; m_hidx = idx; m_hvld = 1; end
            else if (m_hvld && m_hidx == idx) begin exp_n = 1; exp_d = {dat, m_hold} & mask; m_hvld = 0; end
            else m_err = 1;
         end
         got_n = is_leaf ? n_leaf : n_query;
         got_d = is_leaf ? c_leaf_data : {9'b0, c_query_data};
         got_a = is_leaf ? int'(c_leaf_addr) : int'(c_query_addr);
         vecs++;
         if (got_n !== exp_n || (n_leaf + n_query + n_node) !== exp_n) begin
            errs++; $display("FAIL pair_wen_count got %0d want %0d (adr %h)", n_leaf + n_query + n_node, exp_n, adr);
         end
         if (exp_n == 1) begin
            vecs++;
            if (got_a !== idx) begin errs++; $display("FAIL pair_waddr got %0d want %0d", got_a, idx); end
            vecs++;
            if (got_d !== exp_d) begin errs++; $display("FAIL pair_wdata got %h want %h", got_d, exp_d); end
         end
         vecs++;
         if (lat !== 1) begin errs++; $display("FAIL pair_latency got %0d want 1", lat); end
         if (i % 5 == 4) begin
            wb_xfer(0, 4'hF, 32'h3000_0004, 32'h0, rd, lat);
            vecs++;
            if (rd !== {30'b0, m_err, m_debug}) begin errs++; $display("FAIL pair_err_rd got %h want %h", rd, {30'b0, m_err, m_debug}); end
         end
      end
   endtask

   task automatic test_node();
      logic [31:0] rd, dat; int lat, idx;
      for (int i = 0; i < 9; i++) begin
         idx = (i == 0) ? 1 : $urandom_range(0, 63);
         dat = (i == 0) ? 32'h0000_B807 : $urandom;
         wb_xfer(1, 4'hF, 32'h3004_0000 | (32'(idx) << 2), dat, rd, lat);
         vecs++;
         if (n_node !== 1 || c_node_addr !== 6'(idx) || c_node_data !== dat[21:0]) begin
            errs++; $display("FAIL node_write got n=%0d a=%0d d=%h want 1/%0d/%h", n_node, c_node_addr, c_node_data, idx, dat[21:0]);
         end
         vecs++;
         if (lat !== 1) begin errs++; $display("FAIL node_latency got %0d want 1", lat); end
      end
      wb_xfer(1, 4'h7, 32'h3004_0008, 32'h1234, rd, lat);
      vecs++;
      if (n_node !== 0) begin errs++; $display("FAIL node_partial_sel got %0d want 0", n_node); end
   endtask

   task automatic test_best();
      logic [31:0] rd; int lat, idx;
      for (int i = 0; i < 512; i++) best_mem[i] = 11'($urandom);
      best_mem[3] = 11'd421;
      for (int i = 0; i < 8; i++) begin
         idx = (i == 0) ? 3 : $urandom_range(0, 511);
         wb_xfer(0, 4'hF, 32'h3003_0000 | (32'(idx) << 3), 32'h0, rd, lat);
         vecs++;
         if (n_ren !== 1 || c_best_addr !== 9'(idx)) begin errs++; $display("FAIL best_ren got n=%0d a=%0d want 1/%0d", n_ren, c_best_addr, idx); end
         vecs++;
         if (rd !== {21'b0, best_mem[idx]}) begin errs++; $display("FAIL best_data got %0d want %0d", rd, best_mem[idx]); end
         vecs++;
         if (lat !== 2 || n_ack !== 1 || ack_after !== 0 || dat_after !== 0) begin
            errs++; $display("FAIL best_ack_shape got lat=%0d acks=%0d after=%b/%h want 2/1/0/0", lat, n_ack, ack_after, dat_after);
         end
      end
      wb_xfer(1, 4'hF, 32'h3003_0010, 32'hFFFF_FFFF, rd, lat);
      vecs++;
      if (n_ren !== 0 || lat !== 1) begin errs++; $display("FAIL best_write got ren=%0d lat=%0d want 0/1", n_ren, lat); end
      // master abandons the read in RD_WAIT: ack still arrives once
      @(posedge wb_clk_i); #1;
      mon_clear(); mon_en = 1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3003_0020;
      @(posedge wb_clk_i); #1 wbs_cyc_i = 0; wbs_stb_i = 0;
      repeat (3) @(negedge wb_clk_i);
      #1 mon_en = 0;
      vecs++;
      if (n_ack !== 1 || n_ren !== 1) begin errs++; $display("FAIL best_drop_stb got acks=%0d ren=%0d want 1/1", n_ack, n_ren); end
   endtask

   task automatic test_start_irq();
      logic [31:0] rd; int lat; logic b;
      do_reset();
      wb_xfer(1, 4'hF, 32'h3000_000C, 32'h1, rd, lat);
      vecs++;
      if (n_start !== 1 || lat !== 1) begin errs++; $display("FAIL start_pulse got n=%0d lat=%0d want 1/1", n_start, lat); end
      wb_xfer(1, 4'h1, 32'h3000_000C, 32'h1, rd, lat);
      vecs++;
      if (n_start !== 0) begin errs++; $display("FAIL start_partial_sel got %0d want 0", n_start); end
      b = 1'($urandom_range(0, 1));
      fsm_busy = b;
      wb_xfer(0, 4'hF, 32'h3000_0010, 32'h0, rd, lat);
      vecs++;
      if (rd !== {31'b0, b}) begin errs++; $display("FAIL busy_rd got %h want %h", rd, {31'b0, b}); end
      @(negedge wb_clk_i);
      vecs++;
      if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_idle got %b want 0", irq_o); end
      @(posedge wb_clk_i); #1 fsm_done = 1;
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      vecs++;
      if (irq_o !== IRQ_EN) begin errs++; $display("FAIL irq_set got %b want %b", irq_o, IRQ_EN); end
      wb_xfer(0, 4'hF, 32'h3000_0008, 32'h0, rd, lat);
      vecs++;
      if (rd !== 32'd1) begin errs++; $display("FAIL done_rd got %h want 1", rd); end
      vecs++;
      if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_clear got %b want 0", irq_o); end
      @(posedge wb_clk_i); #1 fsm_done = 0;
   endtask

   task automatic test_unmapped();
      logic [31:0] adrs [8] = '{32'h3005_0000, 32'h2FFF_FFFC, 32'h3000_0014, 32'h3000_0001,
                                32'h3001_0000, 32'h3002_0004, 32'h3004_0000, 32'h3000_000C};
      logic [31:0] rd; int lat; logic w;
      for (int i = 0; i < 8; i++) begin
         w = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         wb_xfer(w, 4'hF, adrs[i], $urandom, rd, lat);
         vecs++;
         if (rd !== 32'h0 || lat !== 1) begin errs++; $display("FAIL unmapped_rd got %h lat=%0d want 0/1 (adr %h)", rd, lat, adrs[i]); end
         vecs++;
         if ((n_node + n_leaf + n_query + n_ren + n_start) !== 0 || {mode_o, debug_o} !== {m_mode, m_debug}) begin
            errs++; $display("FAIL unmapped_side_effect got strobes=%0d md=%b want 0/%b", n_node + n_leaf + n_query + n_ren + n_start, {mode_o, debug_o}, {m_mode, m_debug});
         end
      end
   endtask

   task automatic test_back_to_back();
      int acks, wens; bit prev, dbl;
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3004_0010; wbs_dat_i = $urandom;
      acks = 0; wens = 0; prev = 0; dbl = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) acks++;
         if (node_wen) wens++;
         if (wbs_ack_o && prev) dbl = 1;
         prev = wbs_ack_o;
      end
      @(posedge wb_clk_i); #1 wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      vecs++;
      if (acks !== 3 || wens !== 3 || dbl) begin errs++; $display("FAIL back_to_back got acks=%0d wens=%0d dbl=%0d want 3/3/0", acks, wens, dbl); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 512; i++) best_mem[i] = '0;
      test_reset();
      test_ctrl();
      test_pairs(1'b1);
      test_pairs(1'b0);
      test_node();
      test_best();
      test_start_irq();
      test_unmapped();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
